// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate BIST: op encodings, FSM states, vector count.
// No timing of its own; no flow control.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int         NUM_VEC  = 4;
  localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Reference model of the gate under test: y = op(a, b). Purely combinational, no flow control.
// Illegal op codes return 0.
module gate_ref
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive 4-vector BIST for a two-input gate; a run lasts 4*(SETTLE+1)+1 cycles from start to done.
// No backpressure: start is accepted only in IDLE, otherwise dropped.
module gate_bist
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE = 1
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a_o,
  output logic       b_o,
  input  logic       c_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic       op_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [1:0] vec, vec_nx;
  logic [3:0] cnt, cnt_nx;
  logic [2:0] op_q, op_q_nx;
  logic       a_nx, b_nx, busy_nx, done_nx, pass_nx, op_err_nx;
  logic [2:0] err_nx;
  logic [3:0] fail_nx;
  logic       exp_y;

  gate_ref u_ref (
    .op (op_q),
    .a  (vec[1]),
    .b  (vec[0]),
    .y  (exp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      vec      <= 2'd0;
      cnt      <= 4'd0;
      op_q     <= 3'd0;
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
      op_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      vec      <= vec_nx;
      cnt      <= cnt_nx;
      op_q     <= op_q_nx;
      a_o      <= a_nx;
      b_o      <= b_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      pass     <= pass_nx;
      err_cnt  <= err_nx;
      fail_vec <= fail_nx;
      op_err   <= op_err_nx;
    end
  end

  // busy/done/pass are computed one state ahead so they are registered yet aligned with the state.
  always_comb begin
    state_nx  = state;
    vec_nx    = vec;
    cnt_nx    = cnt;
    op_q_nx   = op_q;
    a_nx      = a_o;
    b_nx      = b_o;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    pass_nx   = pass;
    err_nx    = err_cnt;
    fail_nx   = fail_vec;
    op_err_nx = op_err;

    case (state)
      ST_IDLE: begin
        if (start) begin
          op_q_nx = op;
          vec_nx  = 2'd0;
          cnt_nx  = 4'd0;
          err_nx  = 3'd0;
          fail_nx = 4'd0;
          pass_nx = 1'b0;
          if (op_legal(op)) begin
            op_err_nx = 1'b0;
            state_nx  = ST_DRIVE;
            a_nx      = 1'b0;
            b_nx      = 1'b0;
            busy_nx   = 1'b1;
          end else begin
            op_err_nx = 1'b1;
            state_nx  = ST_FIN;
            done_nx   = 1'b1;
          end
        end
      end

      ST_DRIVE: begin
        busy_nx = 1'b1;
        if (cnt == SETTLE_LAST) begin
          cnt_nx   = 4'd0;
          state_nx = ST_SAMPLE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (c_i != exp_y) begin
          err_nx       = err_cnt + 3'd1;
          fail_nx[vec] = 1'b1;
        end
        if (vec == LAST_VEC) begin
          state_nx = ST_FIN;
          done_nx  = 1'b1;
          pass_nx  = (err_nx == 3'd0) && !op_err;
        end else begin
          vec_nx   = vec + 2'd1;
          state_nx = ST_DRIVE;
          busy_nx  = 1'b1;
          a_nx     = vec_nx[1];
          b_nx     = vec_nx[0];
        end
      end

      ST_FIN: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
